// File: rtl/ex_mem_stage.sv
// Execute->memory pipeline boundary.
// Holds up to two instructions (MAIN drives the outputs, SKID catches one extra)
// so that in_ready is a flop and never depends on out_ready or in_valid.
// Conditional branches resolve on accept, using the ALU zero flag.
//
// state | meaning
// EMPTY | no instruction held, in_ready=1, out_valid=0
// ONE   | MAIN holds an instruction, in_ready=1, out_valid=1
// FULL  | MAIN and SKID both hold one, in_ready=0, out_valid=1
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic              in_alu_zero,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_is_branch,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } payload_t;

  state_t   state, state_nxt;
  payload_t main_q, skid_q, in_payload;
  logic     accept, transfer;
  logic     load_main_in, load_main_skid, load_skid_in;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign transfer  = out_valid & out_ready;

  // Branches still flow downstream but must not write anything.
  assign in_payload = '{alu_result: in_alu_out,
                        store_data: in_store_data,
                        rd:         in_rd,
                        reg_write:  in_reg_write & ~in_is_branch,
                        mem_read:   in_mem_read & ~in_is_branch,
                        mem_write:  in_mem_write & ~in_is_branch};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next state and entry load controls; flush overrides accept and transfer.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && transfer) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt    = FULL;
            load_skid_in = 1'b1;
          end else if (transfer) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (transfer) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Entry storage: MAIN loads from input or from SKID, SKID only from input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_payload;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid_in)        skid_q <= in_payload;
    end
  end

  // Branch resolution happens at accept, independent of the memory stage stalling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else begin
      branch_taken <= accept & in_is_branch & in_alu_zero & ~flush;
      if (accept && in_is_branch && !flush) branch_target <= in_pc + in_imm;
    end
  end

  assign out_alu_result = main_q.alu_result;
  assign out_store_data = main_q.store_data;
  assign out_rd         = main_q.rd;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;

endmodule
